// File: rtl/pim_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pim_serial_pkg
// Description : Shared definitions for the bit-serial PIM blocks: FSM state
//               encoding common to every serial operator.
// Revision    : 1.0 - initial release
// ============================================================================
package pim_serial_pkg;

    localparam int c_STATE_W = 2;

    // Common three-phase sequencing of a bit-serial operator
    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pim_state_t;

endpackage
`default_nettype wire

// File: rtl/adder_1bit_half.sv
`default_nettype none
// ============================================================================
// Module      : adder_1bit_half
// Description : One-bit half adder, S = A ^ B, C = A & B. IMPL_TYPE selects a
//               gate-level or an arithmetic description of the same function.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_1bit_half #(
    parameter int IMPL_TYPE = 0
) (
    input  logic A,
    input  logic B,
    output logic S,
    output logic C
);

    generate
        if (IMPL_TYPE == 0) begin : g_gate
            assign S = A ^ B;
            assign C = A & B;
        end else begin : g_arith
            logic [1:0] w_sum2;
            assign w_sum2 = {1'b0, A} + {1'b0, B};
            assign S      = w_sum2[0];
            assign C      = w_sum2[1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sign_apply_serial.sv
`default_nettype none
// ============================================================================
// Module      : sign_apply_serial
// Description : Bit-serial sign application. Converts an unsigned magnitude
//               plus negate flag into a two's-complement result, one bit per
//               clock LSB-first (invert-and-add-one via a half adder chain),
//               with a signed-overflow flag computed at accept time.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_apply_serial
    import pim_serial_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mag,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    pim_state_t         r_state;
    pim_state_t         w_state_nxt;
    logic               r_rdy_en;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_neg;
    logic               r_ovf;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_a;
    logic               w_sum;
    logic               w_cout;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_last;
    logic               w_ovf_calc;

    // Conditional inversion of the current bit; the +1 of negation enters as
    // the initial carry.
    assign w_a = r_mag[0] ^ r_neg;

    adder_1bit_half #(
        .IMPL_TYPE (IMPL_TYPE)
    ) u_ha (
        .A (w_a),
        .B (r_carry),
        .S (w_sum),
        .C (w_cout)
    );

    // Only 2^(WIDTH-1) negated fits as the most negative value; any other
    // magnitude with the top bit set overflows.
    assign w_ovf_calc = in_neg ? (in_mag[WIDTH-1] & (|in_mag[WIDTH-2:0]))
                               : in_mag[WIDTH-1];

    assign w_accept  = w_in_ready & r_rdy_en & in_valid;
    assign w_last    = (r_cnt == c_LAST);
    assign in_ready  = w_in_ready & r_rdy_en;
    assign out_valid = w_out_valid;
    assign out_data  = r_result;
    assign out_ovf   = r_ovf;
    assign busy      = (r_state != ST_IDLE);

    // State register; r_rdy_en delays the first accept by one edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture at accept, then one LSB-first bit per edge while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mag   <= in_mag;
            r_carry <= in_neg;
            r_neg   <= in_neg;
            r_ovf   <= w_ovf_calc;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_mag    <= {1'b0, r_mag[WIDTH-1:1]};
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_carry  <= w_cout;
            if (!w_last) r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sign_apply_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sign_apply_serial
// Description : Self-checking bench for sign_apply_serial at WIDTH=8:
//               vector table, hold/reset sequences and a streamed sweep
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_apply_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_mag = '0;
    logic         in_neg = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] mag;
        logic       neg;
        logic [7:0] d;
        logic       o;
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] q_mag[$];
    logic       q_neg[$];

    sign_apply_serial #(
        .WIDTH     (W),
        .IMPL_TYPE (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: signed value of the request, wrapped to W bits, overflow when
    // outside the signed W-bit range.
    function automatic logic [8:0] model(input logic [7:0] mag, input logic neg);
        int v;
        logic [7:0] d;
        logic o;
        v = neg ? -int'(mag) : int'(mag);
        d = v[7:0];
        o = (v > 127) || (v < -128);
        return {o, d};
    endfunction

    // One operation with out_ready high; checks accept, latency, result, release
    task automatic do_op(input logic [7:0] mag, input logic neg,
                         input logic [7:0] ed, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        in_mag = mag; in_neg = neg; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, ".latency"}, 32'(lat), 32'd8);
        check({nm, ".data"}, 32'(out_data), 32'(ed));
        check({nm, ".ovf"}, 32'(out_ovf), 32'(eo));
        @(posedge clk); #1;
        check({nm, ".released"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    // Streamed operands from q_mag/q_neg, in_valid kept high between accepts
    task automatic run_stream(input bit stalls, input string tag);
        int idx = 0, got = 0, cyc = 0, last_acc = -1, bad_ii = 0, n;
        logic [8:0] exp_q[$];
        logic [8:0] e;
        n = q_mag.size();
        while (got < n && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (idx < n) begin
                in_valid = 1'b1; in_mag = q_mag[idx]; in_neg = q_neg[idx];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, ".spurious"}, 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s.res%0d", tag, got), {23'd0, out_ovf, out_data}, 32'(e));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_mag, in_neg));
                if (!stalls && last_acc >= 0 && (cyc - last_acc) != W + 2) bad_ii++;
                last_acc = cyc;
                idx++;
            end
        end
        check({tag, ".completed"}, 32'(got), 32'(n));
        if (!stalls) check({tag, ".interval"}, 32'(bad_ii), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        q_mag.delete(); q_neg.delete();
    endtask

    initial begin
        int seen;
        logic [7:0] held;
        int j;
        logic [7:0] tmp;
        int xs[255];

        tbl[0] = '{8'h05, 1'b1, 8'hFB, 1'b0};
        tbl[1] = '{8'h80, 1'b1, 8'h80, 1'b0};
        tbl[2] = '{8'h81, 1'b1, 8'h7F, 1'b1};
        tbl[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{8'h90, 1'b0, 8'h90, 1'b1};
        tbl[5] = '{8'h7F, 1'b0, 8'h7F, 1'b0};
        tbl[6] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
        tbl[7] = '{8'hFF, 1'b1, 8'h01, 1'b1};
        tbl[8] = '{8'h01, 1'b1, 8'hFF, 1'b0};

        // Reset state, with an offered operand that must not be taken
        in_valid = 1'b1; in_mag = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        check("rst.outs", {27'd0, in_ready, out_valid, busy, out_ovf, 1'b0}, 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst.ready_second_edge", 32'(in_ready), 32'd1);

        // Vector table
        for (int i = 0; i < 9; i++)
            do_op(tbl[i].mag, tbl[i].neg, tbl[i].d, tbl[i].o, $sformatf("tbl%0d", i));

        // Result held while the sink stalls; inputs ignored meanwhile
        @(negedge clk);
        in_mag = 8'h33; in_neg = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 20) begin @(posedge clk); #1; seen++; end
        check("hold.latency", 32'(seen), 32'd8);
        held = out_data;
        check("hold.data", 32'(held), 32'hCD);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mag = 8'(k + 1); in_neg = 1'b0;
            #1;
            check($sformatf("hold.c%0d", k), {21'd0, out_valid, in_ready, busy, out_ovf, out_data},
                  {21'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hCD});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold.release", {29'd0, out_valid, in_ready, busy}, 32'b010);

        // Reset in the middle of RUN discards the operand
        @(negedge clk);
        in_mag = 8'h55; in_neg = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.outs", {20'd0, in_ready, out_valid, busy, out_ovf, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst.no_valid", 32'(seen), 32'd0);
        do_op(8'h7F, 1'b1, 8'h81, 1'b0, "midrst.next");

        // Full signed sweep in shuffled order, back-to-back
        for (int x = -127; x <= 127; x++) xs[x + 127] = x;
        for (int i = 254; i > 0; i--) begin
            j = $urandom_range(0, i);
            seen = xs[i]; xs[i] = xs[j]; xs[j] = seen;
        end
        for (int i = 0; i < 255; i++) begin
            tmp = (xs[i] < 0) ? 8'(-xs[i]) : 8'(xs[i]);
            q_mag.push_back(tmp);
            q_neg.push_back(xs[i] < 0);
        end
        run_stream(1'b0, "sweep");

        // Random magnitudes and signs with a stalling sink
        for (int i = 0; i < 40; i++) begin
            q_mag.push_back(8'($urandom));
            q_neg.push_back(1'($urandom));
        end
        run_stream(1'b1, "rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
